mandelbrot_pixel_sink: RTL

Downstream consumer of the pipelined Mandelbrot core. Captures each `(x, y, i)` result on the core's `next_out` strobe and buffers it in a small FIFO, because the core has no backpressure. Maps the iteration count to an 8-bit grey level and writes it to a linear framebuffer port under a valid/ready handshake. Tracks completion of a frame and flags data loss.

---
 rtl/mandelbrot_pkg.sv | 25 ++
 rtl/mandelbrot_sink_fifo.sv | 47 ++++
 rtl/mandelbrot_pixel_sink.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mandelbrot_pkg.sv
// Shared widths, FSM state encoding and result record for the Mandelbrot pixel sink.
package mandelbrot_pkg;

   localparam int CW = 11;
   localparam int IW = 16;
   localparam int AW = 22;
   localparam int NW = 23;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = S_IDLE,
      RUN  = S_RUN,
      DONE = S_DONE
   } state_e;

   typedef struct packed {
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      logic [IW-1:0] i;
   } result_t;

endpackage

// File: rtl/mandelbrot_sink_fifo.sv
// Synchronous result FIFO; pointers carry a wrap bit so full and empty are unambiguous.
module mandelbrot_sink_fifo
   import mandelbrot_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    clr,
   input  logic    push,
   input  logic    pop,
   input  result_t din,
   output result_t dout,
   output logic    full,
   output logic    empty
);

   localparam int PW = $clog2(DEPTH);

   result_t       mem_q [DEPTH];
   logic [PW:0]   wr_ptr_q;
   logic [PW:0]   rd_ptr_q;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign dout  = mem_q[rd_ptr_q[PW-1:0]];

   // Storage is not reset; only the pointers define valid contents.
   always_ff @(posedge clk) begin
      if (push && !clr) mem_q[wr_ptr_q[PW-1:0]] <= din;
   end

   // Pointer update; clr empties the queue in one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

endmodule

// File: rtl/mandelbrot_pixel_sink.sv
// Buffers Mandelbrot core results and writes grey-level pixels to a linear framebuffer.
//
//   state | meaning
//   IDLE  | after reset, results ignored
//   RUN   | capturing results, counting accepted writes
//   DONE  | frame complete, results ignored, leftovers drain uncounted
module mandelbrot_pixel_sink
   import mandelbrot_pkg::*;
#(
   parameter int RESX        = 640,
   parameter int RESY        = 480,
   parameter int IMAX        = 15,
   parameter int DEPTH       = 16,
   parameter int COLOR_SHIFT = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          in_valid,
   input  logic [CW-1:0] in_x,
   input  logic [CW-1:0] in_y,
   input  logic [IW-1:0] in_i,
   output logic          fb_we,
   input  logic          fb_ready,
   output logic [AW-1:0] fb_addr,
   output logic [7:0]    fb_data,
   output logic          busy,
   output logic          frame_done,
   output logic [NW-1:0] pixels_written,
   output logic          overflow,
   output logic          range_err
);

   localparam logic [CW:0]   RESX_C  = (CW+1)'(RESX);
   localparam logic [CW:0]   RESY_C  = (CW+1)'(RESY);
   localparam logic [AW-1:0] RESX_A  = AW'(RESX);
   localparam logic [NW-1:0] FRAME_C = NW'(RESX * RESY);
   localparam logic [IW-1:0] IMAX_C  = IW'(IMAX);

   state_e          state_q, state_d;
   logic            we_q, we_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [7:0]      data_q, data_d;
   logic [NW-1:0]   cnt_q, cnt_d;
   logic            ovf_q, ovf_d;
   logic            rng_q, rng_d;

   result_t         fifo_dout;
   result_t         fifo_din;
   logic            fifo_full, fifo_empty;
   logic            push, pop, accept, in_range, capture;
   logic [IW+7:0]   shifted;
   logic [7:0]      grey;
   logic [AW-1:0]   addr_calc;

   assign accept   = we_q && fb_ready;
   assign in_range = ({1'b0, in_x} < RESX_C) && ({1'b0, in_y} < RESY_C);
   assign capture  = (state_q == RUN) && in_valid && !start;
   assign pop      = !fifo_empty && (!we_q || accept) && !start;
   assign push     = capture && in_range && (!fifo_full || pop);
   assign fifo_din = '{x: in_x, y: in_y, i: in_i};

   mandelbrot_sink_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start),
      .push  (push),
      .pop   (pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Colour map and linear address for the entry at the FIFO head.
   always_comb begin
      shifted   = {8'd0, fifo_dout.i} << COLOR_SHIFT;
      grey      = (|shifted[IW+7:8]) ? 8'hFF : shifted[7:0];
      if (fifo_dout.i >= IMAX_C) grey = 8'd0;
      addr_calc = AW'(fifo_dout.y) * RESX_A + AW'(fifo_dout.x);
   end

   // Next-state logic for the FSM, output register, counter and sticky flags.
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      rng_d   = rng_q;
      if (start) begin
         state_d = RUN;
         we_d    = 1'b0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
         rng_d   = 1'b0;
      end else begin
         if (pop) begin
            we_d   = 1'b1;
            addr_d = addr_calc;
            data_d = grey;
         end else if (accept) begin
            we_d = 1'b0;
         end
         if (capture && !in_range) rng_d = 1'b1;
         if (capture && in_range && fifo_full && !pop) ovf_d = 1'b1;
         if ((state_q == RUN) && accept && (cnt_q != FRAME_C)) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q + 1'b1 == FRAME_C) state_d = DONE;
         end
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         rng_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         rng_q   <= rng_d;
      end
   end

   assign fb_we          = we_q;
   assign fb_addr        = addr_q;
   assign fb_data        = data_q;
   assign busy           = (state_q == RUN);
   assign frame_done     = (state_q == DONE);
   assign pixels_written = cnt_q;
   assign overflow       = ovf_q;
   assign range_err      = rng_q;

endmodule
